// File: rtl/flash_pkg.sv
// Shared flash definitions: opcodes, page geometry and reader state encoding.
// Also used by the flash programming sequence.
// No logic; constants, types and an address helper only.
package flash_pkg;

  localparam logic [7:0] FLASH_WREN = 8'h06;
  localparam logic [7:0] FLASH_RFSR = 8'h70;
  localparam logic [7:0] FLASH_BE   = 8'hC7;
  localparam logic [7:0] FLASH_PP   = 8'h02;
  localparam logic [7:0] FLASH_READ = 8'h03;

  localparam int          PAGE_BYTES = 256;
  localparam int          PAGE_WORDS = PAGE_BYTES / 4;
  localparam int          MAX_PAGES  = 65536;
  localparam logic [23:0] BASE_ADDR  = 24'h000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_ADDR2,
    ST_ADDR3,
    ST_EXEC,
    ST_COLLECT,
    ST_PUSH,
    ST_DONE
  } state_t;

  // Flash byte address of a page; the 24-bit sum wraps naturally.
  function automatic logic [23:0] page_addr(input logic [23:0] base, input logic [16:0] page);
    return base + {page[15:0], 8'h00};
  endfunction

endpackage

// File: rtl/flash_reader_if.sv
// Command / read-buffer port between a flash client and flash_interface.
// master: client side (issues commands, pops read buffer); slave: flash_interface side.
// Write-buffer and read-buffer pushes/pops are 1-cycle pulses gated by full/empty.
interface flash_reader_if;
  logic [7:0] flash_instruction;
  logic       flash_execute;
  logic [8:0] flash_bytes_to_read;
  logic       flash_busy;
  logic [7:0] flash_write_buffer_data;
  logic       flash_write_buffer_write;
  logic       flash_write_buffer_full;
  logic [7:0] flash_read_buffer_q;
  logic       flash_read_buffer_empty;
  logic       flash_read_buffer_read;

  modport master (
    output flash_instruction, flash_execute, flash_bytes_to_read,
    output flash_write_buffer_data, flash_write_buffer_write, flash_read_buffer_read,
    input  flash_busy, flash_write_buffer_full, flash_read_buffer_q, flash_read_buffer_empty
  );

  modport slave (
    input  flash_instruction, flash_execute, flash_bytes_to_read,
    input  flash_write_buffer_data, flash_write_buffer_write, flash_read_buffer_read,
    output flash_busy, flash_write_buffer_full, flash_read_buffer_q, flash_read_buffer_empty
  );
endinterface

// File: rtl/flash_reader.sv
// Reads num_pages flash pages (one FLASH_READ each) and streams big-endian 32-bit words.
// Ports: clk/reset, start/num_pages/busy/done control, flash (master modport), out_data/out_write/out_full.
// Latency start->first address push 2 cycles; holds a word indefinitely while out_full.
module flash_reader
  import flash_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [16:0]        num_pages,
  output logic               busy,
  output logic               done,
  flash_reader_if.master     flash,
  output logic [31:0]        out_data,
  output logic               out_write,
  input  logic               out_full
);

  state_t      state, state_n;
  logic [16:0] pages, pages_n;
  logic [16:0] page, page_n;
  logic [8:0]  byte_cnt, byte_cnt_n;
  logic [31:0] word, word_n;
  logic [23:0] addr;

  // All outputs are registered; *_n are their next values.
  logic        busy_n, done_n, exec, exec_n, wb_write, wb_write_n, rb_read, rb_read_n, out_write_n;
  logic [7:0]  instr, instr_n, wb_data, wb_data_n;
  logic [8:0]  btr, btr_n;
  logic [31:0] out_data_n;

  assign addr = page_addr(BASE_ADDR, page);

  always_comb begin
    state_n     = state;
    pages_n     = pages;
    page_n      = page;
    byte_cnt_n  = byte_cnt;
    word_n      = word;
    busy_n      = busy;
    done_n      = 1'b0;
    exec_n      = 1'b0;
    wb_write_n  = 1'b0;
    rb_read_n   = 1'b0;
    out_write_n = 1'b0;
    instr_n     = instr;
    btr_n       = btr;
    wb_data_n   = wb_data;
    out_data_n  = out_data;

    case (state)
      ST_IDLE: begin
        if (start) begin
          pages_n = (num_pages > 17'(MAX_PAGES)) ? 17'(MAX_PAGES) : num_pages;
          page_n  = '0;
          busy_n  = 1'b1;
          state_n = (num_pages == '0) ? ST_DONE : ST_ADDR1;
        end
      end
      ST_ADDR1: begin
        if (!flash.flash_busy && !flash.flash_write_buffer_full) begin
          wb_data_n  = addr[23:16];
          wb_write_n = 1'b1;
          state_n    = ST_ADDR2;
        end
      end
      ST_ADDR2: begin
        if (!flash.flash_busy && !flash.flash_write_buffer_full) begin
          wb_data_n  = addr[15:8];
          wb_write_n = 1'b1;
          state_n    = ST_ADDR3;
        end
      end
      ST_ADDR3: begin
        if (!flash.flash_busy && !flash.flash_write_buffer_full) begin
          wb_data_n  = addr[7:0];
          wb_write_n = 1'b1;
          state_n    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!flash.flash_busy) begin
          exec_n     = 1'b1;
          instr_n    = FLASH_READ;
          btr_n      = 9'(PAGE_BYTES);
          byte_cnt_n = '0;
          state_n    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // rb_read high means a pop is in flight this cycle and the empty flag /
        // show-ahead byte have not caught up yet, so skip a cycle.
        if (!flash.flash_read_buffer_empty && !rb_read) begin
          rb_read_n  = 1'b1;
          word_n     = {word[23:0], flash.flash_read_buffer_q};
          byte_cnt_n = byte_cnt + 9'd1;
          if (byte_cnt[1:0] == 2'd3) state_n = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!out_full) begin
          out_write_n = 1'b1;
          out_data_n  = word;
          if (byte_cnt == 9'(PAGE_BYTES)) begin
            page_n  = page + 17'd1;
            state_n = (page + 17'd1 == pages) ? ST_DONE : ST_ADDR1;
          end else begin
            state_n = ST_COLLECT;
          end
        end
      end
      ST_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pages     <= '0;
      page      <= '0;
      byte_cnt  <= '0;
      word      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      exec      <= 1'b0;
      wb_write  <= 1'b0;
      rb_read   <= 1'b0;
      out_write <= 1'b0;
      instr     <= '0;
      btr       <= '0;
      wb_data   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      pages     <= pages_n;
      page      <= page_n;
      byte_cnt  <= byte_cnt_n;
      word      <= word_n;
      busy      <= busy_n;
      done      <= done_n;
      exec      <= exec_n;
      wb_write  <= wb_write_n;
      rb_read   <= rb_read_n;
      out_write <= out_write_n;
      instr     <= instr_n;
      btr       <= btr_n;
      wb_data   <= wb_data_n;
      out_data  <= out_data_n;
    end
  end

  assign flash.flash_instruction        = instr;
  assign flash.flash_execute            = exec;
  assign flash.flash_bytes_to_read      = btr;
  assign flash.flash_write_buffer_data  = wb_data;
  assign flash.flash_write_buffer_write = wb_write;
  assign flash.flash_read_buffer_read   = rb_read;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: behavioural flash_interface and output FIFO model.
// Flash byte at address a is a[7:0]+a[15:8], so page p word w = bytes 4w+p..4w+3+p.
// out_full is driven directly by the stimulus to exercise backpressure.
module tb_flash_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] num_pages;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_write;
  logic        out_full;

  int tests_run = 0;
  int tests_failed = 0;

  flash_reader_if fif ();

  flash_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_pages (num_pages),
    .busy      (busy),
    .done      (done),
    .flash     (fif),
    .out_data  (out_data),
    .out_write (out_write),
    .out_full  (out_full)
  );

  always #5 clk = ~clk;

  // ---------------- flash_interface + output FIFO model ----------------
  logic [7:0]  rbq[$];
  logic [31:0] outq[$];
  logic [7:0]  addr_log[$];
  logic [7:0]  exec_instr[$];
  logic [8:0]  exec_btr[$];
  logic [23:0] cur_addr;
  logic [23:0] pend_addr;
  int          busy_cnt;
  int          underflow = 0;

  always @(posedge clk) begin
    if (reset) begin
      rbq.delete();
      busy_cnt = 0;
      cur_addr = '0;
      fif.flash_busy              <= 1'b0;
      fif.flash_read_buffer_empty <= 1'b1;
      fif.flash_read_buffer_q     <= '0;
    end else begin
      if (fif.flash_write_buffer_write) begin
        addr_log.push_back(fif.flash_write_buffer_data);
        cur_addr = {cur_addr[15:0], fif.flash_write_buffer_data};
      end
      if (fif.flash_execute) begin
        exec_instr.push_back(fif.flash_instruction);
        exec_btr.push_back(fif.flash_bytes_to_read);
        pend_addr = cur_addr;
        busy_cnt  = 4;
        fif.flash_busy <= 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          for (int i = 0; i < 256; i++) begin
            logic [23:0] a;
            a = pend_addr + 24'(i);
            rbq.push_back(a[7:0] + a[15:8]);
          end
          fif.flash_busy <= 1'b0;
        end
      end
      if (fif.flash_read_buffer_read) begin
        if (rbq.size() == 0) underflow++;
        else void'(rbq.pop_front());
      end
      fif.flash_read_buffer_empty <= (rbq.size() == 0);
      fif.flash_read_buffer_q     <= (rbq.size() != 0) ? rbq[0] : 8'h00;
      if (out_write) outq.push_back(out_data);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int page, input int w);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*w + page);
    b1 = 8'(4*w + 1 + page);
    b2 = 8'(4*w + 2 + page);
    b3 = 8'(4*w + 3 + page);
    return {b0, b1, b2, b3};
  endfunction

  task automatic check_page(input int base, input int page);
    logic [31:0] got;
    for (int w = 0; w < 64; w++) begin
      got = (base + w < outq.size()) ? outq[base + w] : 32'hxxxxxxxx;
      check($sformatf("p%0d_word%0d", page, w), got, exp_word(page, w));
    end
  endtask

  task automatic clear_logs();
    outq.delete();
    addr_log.delete();
    exec_instr.delete();
    exec_btr.delete();
  endtask

  // Returns at the negedge after the one where start was first driven high.
  task automatic pulse_start(input logic [16:0] n);
    @(negedge clk);
    start = 1'b1;
    num_pages = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_execs(input string tag, input int n);
    check({tag, "_exec_count"}, exec_instr.size(), n);
    for (int i = 0; i < exec_instr.size(); i++) begin
      check($sformatf("%s_instr%0d", tag, i), exec_instr[i], 32'h03);
      check($sformatf("%s_btr%0d", tag, i), exec_btr[i], 32'd256);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int hold_writes;
    logic [7:0] exp_addr [9];

    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    num_pages = '0;
    out_full = 1'b0;
    fif.flash_write_buffer_full = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_write", out_write, 0);
    check("rst_execute", fif.flash_execute, 0);
    check("rst_wb_write", fif.flash_write_buffer_write, 0);
    check("rst_rb_read", fif.flash_read_buffer_read, 0);
    check("rst_instr", fif.flash_instruction, 0);
    reset = 1'b0;

    // 1: single page, latency and content
    clear_logs();
    pulse_start(17'd1);
    check("t1_busy_n1", busy, 1);
    check("t1_wb_write_n1", fif.flash_write_buffer_write, 0);
    @(negedge clk);
    check("t1_wb_write_n2", fif.flash_write_buffer_write, 1);
    check("t1_wb_data_n2", fif.flash_write_buffer_data, 8'h00);
    wait_done(3000);
    check("t1_busy_at_done", busy, 0);
    check("t1_word_count", outq.size(), 64);
    check_page(0, 0);
    check("t1_addr_count", addr_log.size(), 3);
    check_execs("t1", 1);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // 2: zero pages
    clear_logs();
    pulse_start(17'd0);
    check("t2_busy_n1", busy, 1);
    check("t2_done_n1", done, 0);
    @(negedge clk);
    check("t2_done_n2", done, 1);
    check("t2_busy_n2", busy, 0);
    repeat (10) @(negedge clk);
    check("t2_exec_count", exec_instr.size(), 0);
    check("t2_word_count", outq.size(), 0);
    check("t2_addr_count", addr_log.size(), 0);

    // 3: three pages
    clear_logs();
    exp_addr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00};
    pulse_start(17'd3);
    wait_done(8000);
    check("t3_addr_count", addr_log.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("t3_addr%0d", i), (i < addr_log.size()) ? addr_log[i] : 8'hxx, exp_addr[i]);
    check_execs("t3", 3);
    check("t3_word_count", outq.size(), 192);
    check_page(0, 0);
    check_page(64, 1);
    check_page(128, 2);

    // 4: backpressure after word 10
    clear_logs();
    pulse_start(17'd1);
    n = 0;
    for (int c = 0; c < 2000 && n < 11; c++) begin
      @(negedge clk);
      if (out_write) n++;
    end
    check("t4_reached_word10", n, 11);
    out_full = 1'b1;
    hold_writes = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_write) hold_writes++;
    end
    check("t4_hold_no_write", hold_writes, 0);
    check("t4_words_before_release", outq.size(), 11);
    out_full = 1'b0;
    wait_done(3000);
    check("t4_word_count", outq.size(), 64);
    check_page(0, 0);

    // 5: reset during byte 37 of page 1
    clear_logs();
    pulse_start(17'd2);
    n = 0;
    for (int c = 0; c < 4000 && n < 256 + 38; c++) begin
      @(negedge clk);
      if (fif.flash_read_buffer_read) n++;
    end
    check("t5_reached_byte37", n, 256 + 38);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_out_write", out_write, 0);
    check("t5_out_data", out_data, 0);
    check("t5_execute", fif.flash_execute, 0);
    check("t5_instr", fif.flash_instruction, 0);
    check("t5_btr", fif.flash_bytes_to_read, 0);
    check("t5_wb_write", fif.flash_write_buffer_write, 0);
    check("t5_wb_data", fif.flash_write_buffer_data, 0);
    check("t5_rb_read", fif.flash_read_buffer_read, 0);
    reset = 1'b0;
    clear_logs();
    pulse_start(17'd1);
    wait_done(3000);
    check("t5_addr_count", addr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t5_addr%0d", i), (i < addr_log.size()) ? addr_log[i] : 8'hxx, 8'h00);
    check("t5_word_count", outq.size(), 64);
    check_page(0, 0);

    // 6: start while busy is ignored
    clear_logs();
    pulse_start(17'd2);
    repeat (50) @(negedge clk);
    check("t6_busy_mid", busy, 1);
    start = 1'b1;
    num_pages = 17'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000);
    check("t6_word_count", outq.size(), 128);
    check_page(0, 0);
    check_page(64, 1);
    repeat (20) @(negedge clk);
    check("t6_idle_after", busy, 0);
    check("t6_exec_count", exec_instr.size(), 2);
    check("t6_words_after", outq.size(), 128);

    check("no_read_underflow", underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
